// File: rtl/alu_result_stage.sv
// Result/flag buffer behind the adder: computes {N,Z,C,V} at push and queues results in a small FIFO.
// Optional saturation on signed overflow is enabled with `define ALU_RESULT_SAT_EN.
module alu_result_stage #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             sum,
  input  logic                   cout,
  input  logic                   overflow,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_result,
  output logic [3:0]             out_flags,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf_sticky,
  input  logic                   ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never
  // waits on ready, and ready depends only on registered occupancy.
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [11:0]   mem_q [DEPTH];

  logic          push, pop;
  logic [7:0]    res_d;
  logic [3:0]    flags_d;

  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    res_d = sum;
`ifdef ALU_RESULT_SAT_EN
    // A negative-looking raw sum on overflow means the true result was too large.
    if (overflow) res_d = sum[7] ? 8'h7F : 8'h80;
`endif
    flags_d[3] = res_d[7];
    flags_d[2] = (res_d == 8'h00);
    flags_d[1] = sub ? ~cout : cout;
    flags_d[0] = overflow;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (push && overflow) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= {res_d, flags_d};
  end

  assign out_result = out_valid ? mem_q[rd_ptr_q][11:4] : 8'h00;
  assign out_flags  = out_valid ? mem_q[rd_ptr_q][3:0]  : 4'h0;
  assign level      = level_q;
  assign ovf_sticky = ovf_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (DEPTH=4); expectations follow ALU_RESULT_SAT_EN when defined.
module tb_alu_result_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] sum = 8'h00;
  logic       cout = 1'b0, overflow = 1'b0, sub = 1'b0;
  logic       out_valid, out_ready = 1'b0;
  logic [7:0] out_result;
  logic [3:0] out_flags;
  logic [2:0] level;
  logic       ovf_sticky, ovf_clr = 1'b0;
  int checks = 0;
  int errors = 0;

  alu_result_stage #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .level(level), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] s, input logic c, input logic o, input logic sb);
    in_valid = v; sum = s; cout = c; overflow = o; sub = sb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_result !== 8'h00 || out_flags !== 4'h0) begin errors++; $display("FAIL reset_head got %h/%b exp 00/0000", out_result, out_flags); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b exp 0", ovf_sticky); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || level !== 3'd1) begin errors++; $display("FAIL basic_latency got v=%b lvl=%0d exp v=1 lvl=1", out_valid, level); end
    checks++; if (out_result !== 8'h05 || out_flags !== 4'b0000) begin errors++; $display("FAIL basic_head got %h/%b exp 05/0000", out_result, out_flags); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_pop got lvl=%0d v=%b exp 0/0", level, out_valid); end
  endtask

  task automatic test_flags();
    logic [7:0] s_t [3];
    logic       c_t [3];
    logic       b_t [3];
    logic [3:0] f_t [3];
    s_t[0] = 8'h00; c_t[0] = 1'b1; b_t[0] = 1'b1; f_t[0] = 4'b0100;
    s_t[1] = 8'hFF; c_t[1] = 1'b0; b_t[1] = 1'b1; f_t[1] = 4'b1010;
    s_t[2] = 8'h00; c_t[2] = 1'b1; b_t[2] = 1'b0; f_t[2] = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, s_t[i], c_t[i], 1'b0, b_t[i]);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (out_result !== s_t[i] || out_flags !== f_t[i]) begin errors++; $display("FAIL flags_%0d got %h/%b exp %h/%b", i, out_result, out_flags, s_t[i], f_t[i]); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_overflow();
    logic [7:0] r_exp;
    logic [3:0] f_exp;
`ifdef ALU_RESULT_SAT_EN
    r_exp = 8'h7F; f_exp = 4'b0001;
`else
    r_exp = 8'h80; f_exp = 4'b1001;
`endif
    drive(1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (out_result !== r_exp || out_flags !== f_exp) begin errors++; $display("FAIL ovf_neg got %h/%b exp %h/%b", out_result, out_flags, r_exp, f_exp); end
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky_set got %b exp 1", ovf_sticky); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`ifdef ALU_RESULT_SAT_EN
    r_exp = 8'h80; f_exp = 4'b1001;
`else
    r_exp = 8'h01; f_exp = 4'b0001;
`endif
    drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (out_result !== r_exp || out_flags !== f_exp) begin errors++; $display("FAIL ovf_pos got %h/%b exp %h/%b", out_result, out_flags, r_exp, f_exp); end
    out_ready = 1'b1;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    out_ready = 1'b0;
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf_sticky); end
    ovf_clr = 1'b1;
    drive(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
    step();
    ovf_clr = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", ovf_sticky); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL ovf_drain got lvl=%0d exp 0", level); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b0);
      step();
      if (i == 3) begin
        checks++; if (in_ready !== 1'b0 || level !== 3'd4) begin errors++; $display("FAIL full_after4 got rdy=%b lvl=%0d exp 0/4", in_ready, level); end
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (level !== 3'd4 || out_result !== 8'h11) begin errors++; $display("FAIL full_refused got lvl=%0d head=%h exp 4/11", level, out_result); end
    step();
    checks++; if (out_result !== 8'h11 || out_valid !== 1'b1) begin errors++; $display("FAIL full_hold got %h v=%b exp 11/1", out_result, out_valid); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_result !== 8'h11 + 8'(i)) begin errors++; $display("FAIL full_drain_%0d got %h exp %h", i, out_result, 8'h11 + 8'(i)); end
      step();
    end
    out_ready = 1'b0;
    checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL full_empty got lvl=%0d v=%b exp 0/0", level, out_valid); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL empty_pop_noop got lvl=%0d exp 0", level); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0); out_ready = 1'b1; step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd2 || out_result !== 8'hA1) begin errors++; $display("FAIL b2b_mid got lvl=%0d head=%h exp 2/a1", level, out_result); end
    drive(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0); step();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_fill got lvl=%0d exp 4", level); end
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0); out_ready = 1'b1; step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); out_ready = 1'b0;
    checks++; if (level !== 3'd3 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_full_pp got lvl=%0d rdy=%b exp 3/1", level, in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_result !== 8'hA2 + 8'(i)) begin errors++; $display("FAIL b2b_order_%0d got %h exp %h", i, out_result, 8'hA2 + 8'(i)); end
      step();
    end
    out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_drain got lvl=%0d exp 0", level); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h31, 1'b0, 1'b1, 1'b0); step();
    drive(1'b1, 8'h32, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (level !== 3'd3 || ovf_sticky !== 1'b1) begin errors++; $display("FAIL mid_pre got lvl=%0d st=%b exp 3/1", level, ovf_sticky); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_async got v=%b lvl=%0d rdy=%b exp 0/0/1", out_valid, level, in_ready); end
    checks++; if (ovf_sticky !== 1'b0 || out_result !== 8'h00) begin errors++; $display("FAIL mid_clear got st=%b head=%h exp 0/00", ovf_sticky, out_result); end
    drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0); out_ready = 1'b1;
    step();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_no_push got lvl=%0d exp 0", level); end
    rst = 1'b0; out_ready = 1'b0;
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (level !== 3'd1 || out_result !== 8'h44) begin errors++; $display("FAIL post_rst_push got lvl=%0d head=%h exp 1/44", level, out_result); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_overflow();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, adder result presented this cycle.
REQ-005 The block SHALL have port in_ready, output, 1, block accepts the presented result.
REQ-006 The block SHALL have port sum, input, 8, adder sum.
REQ-007 The block SHALL have port cout, input, 1, adder carry out.
REQ-008 The block SHALL have port overflow, input, 1, adder signed overflow.
REQ-009 The block SHALL have port sub, input, 1, operation was subtraction (adder cin).
REQ-010 The block SHALL have port out_valid, output, 1, head entry available.
REQ-011 The block SHALL have port out_ready, input, 1, consumer takes the head entry.
REQ-012 The block SHALL have port out_result, output, 8, head result.
REQ-013 The block SHALL have port out_flags, output, 4, head flags {N,Z,C,V} (bit3..bit0).
REQ-014 The block SHALL have port level, output, log2(DEPTH)+1, current occupancy.
REQ-015 The block SHALL have port ovf_sticky, output, 1, set when any accepted entry had V=1.
REQ-016 The block SHALL have port ovf_clr, input, 1, synchronous clear of ovf_sticky.

Function
REQ-017 The block SHALL push an entry when in_valid && in_ready, and pop when out_valid && out_ready.
REQ-018 The block SHALL drive in_ready = (level != DEPTH); push is refused when full, even if a pop occurs in the same cycle.
REQ-019 The block SHALL drive out_valid = (level != 0); out_result/out_flags are registered head contents, no combinational input-to-output path.
REQ-020 Latency SHALL be one cycle: an entry pushed into an empty block appears with out_valid=1 on the next cycle.
REQ-021 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and preserve order.
REQ-022 Pop when empty and push when full SHALL be no-ops; no pointer or level change.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH.
REQ-024 Flags SHALL be computed at push: N = result[7]; Z = (result == 0); C = cout when sub=0, ~cout (borrow) when sub=1; V = overflow.
REQ-025 Stored result SHALL be sum, except as modified by REQ-031.
REQ-026 ovf_sticky SHALL set on cycle after a push with overflow=1; ovf_clr SHALL clear it; if ovf_clr and such a push coincide, set wins.
REQ-027 Output holds (out_result, out_flags) SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-028 rst asserted SHALL immediately force level=0, pointers=0, out_valid=0, in_ready=1, out_result=8'h00, out_flags=4'h0, ovf_sticky=0.
REQ-029 rst asserted mid-operation SHALL discard all buffered entries; no pop or push completes in that cycle.
REQ-030 After rst deasserts, the first push SHALL be accepted on the first rising edge.

Configuration
REQ-031 With macro ALU_RESULT_SAT_EN defined, a push with overflow=1 SHALL store 8'h7F when sum[7]=1 and 8'h80 when sum[7]=0; N and Z SHALL reflect the saturated value; V SHALL still be 1.
REQ-032 Without ALU_RESULT_SAT_EN, the raw sum SHALL be stored in all cases.

Verification
REQ-033 Reset, then push sum=8'h05, cout=0, ovf=0, sub=0 -> next cycle out_valid=1, out_result=8'h05, out_flags=4'b0000, level=1.
REQ-034 Push sub=1, sum=8'h00, cout=1 -> flags N=0, Z=1, C=0, V=0 (no borrow).
REQ-035 Push overflow=1, sum=8'h80, sub=0 -> without macro result 8'h80, flags 4'b1001, ovf_sticky=1; with ALU_RESULT_SAT_EN result 8'h7F, flags 4'b0001.
REQ-036 With DEPTH=4, out_ready=0, push 5 values -> in_ready=0 after 4th, 5th not accepted, level=4; then drain -> first 4 values in order.
REQ-037 At level=2, push and pop in same cycle -> level stays 2, order preserved; at level=4 push+pop -> only pop occurs, level=3.
REQ-038 Assert rst with level=3 -> same cycle out_valid=0, level=0; ovf_clr with coincident overflow push -> ovf_sticky remains 1.
